// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer between the memory stage and datamemory.
package store_buffer_pkg;

  localparam int unsigned SB_ADDR_W = 9;
  localparam int unsigned SB_DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
    logic [2:0]           funct3;
  } sb_entry_t;

  function automatic int unsigned ptr_wrap_inc(int unsigned ptr, int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Core-side store/load requests and datamemory port signals owned by the store buffer.
interface store_buffer_if #(
  parameter int unsigned DM_ADDRESS = store_buffer_pkg::SB_ADDR_W,
  parameter int unsigned DATA_W     = store_buffer_pkg::SB_DATA_W
);
  logic                  st_valid;
  logic [DM_ADDRESS-1:0] st_addr;
  logic [DATA_W-1:0]     st_data;
  logic [2:0]            st_funct3;
  logic                  st_ready;
  logic                  ld_valid;
  logic [DM_ADDRESS-1:0] ld_addr;
  logic [2:0]            ld_funct3;
  logic                  ld_stall;
  logic                  dm_read;
  logic                  dm_write;
  logic [DM_ADDRESS-1:0] dm_addr;
  logic [DATA_W-1:0]     dm_wd;
  logic [2:0]            dm_funct3;
  logic                  empty;

  modport master (
    output st_valid, st_addr, st_data, st_funct3, ld_valid, ld_addr, ld_funct3,
    input  st_ready, ld_stall, dm_read, dm_write, dm_addr, dm_wd, dm_funct3, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_funct3, ld_valid, ld_addr, ld_funct3,
    output st_ready, ld_stall, dm_read, dm_write, dm_addr, dm_wd, dm_funct3, empty
  );
endinterface

// File: rtl/sb_fifo.sv
// In-order circular store FIFO; exposes every entry and its valid bit for hazard compare.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  sb_entry_t        push_entry,
  input  logic             pop,
  output sb_entry_t        head_entry,
  output sb_entry_t        entries [DEPTH],
  output logic [DEPTH-1:0] valid,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  sb_entry_t        mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PtrW-1:0]  head_q, tail_q;
  logic [CntW-1:0]  count_q;
  logic             push_en, pop_en;

  // Overruns and underruns are dropped rather than corrupting pointers.
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_en) begin
        mem_q[tail_q]   <= push_entry;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= PtrW'(ptr_wrap_inc(32'(tail_q), DEPTH));
      end
      if (pop_en) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= PtrW'(ptr_wrap_inc(32'(head_q), DEPTH));
      end
      if (push_en && !pop_en) begin
        count_q <= count_q + CntW'(1);
      end else if (pop_en && !push_en) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  assign head_entry = mem_q[head_q];
  assign entries    = mem_q;
  assign valid      = valid_q;
  assign full       = (count_q == CntW'(DEPTH));
  assign empty      = (count_q == '0);

endmodule

// File: rtl/store_buffer.sv
// Store buffer: queues stores and arbitrates datamemory's single port between loads and drains.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave sb
);
  sb_entry_t        push_entry, head_entry;
  sb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             full, empty;
  logic             hit, load_grant, drain;

  assign push_entry = '{addr: sb.st_addr, data: sb.st_data, funct3: sb.st_funct3};

  sb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (sb.st_valid),
    .push_entry(push_entry),
    .pop       (drain),
    .head_entry(head_entry),
    .entries   (entries),
    .valid     (valid),
    .full      (full),
    .empty     (empty)
  );

  // Full word-address match, independent of access size.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i].addr == sb.ld_addr)) hit = 1'b1;
    end
    hit = hit && sb.ld_valid;
  end

  always_comb begin
    load_grant   = sb.ld_valid && !hit && !full;
    drain        = !load_grant && !empty;
    sb.dm_read   = load_grant;
    sb.dm_write  = drain;
    sb.dm_addr   = load_grant ? sb.ld_addr : head_entry.addr;
    sb.dm_funct3 = load_grant ? sb.ld_funct3 : head_entry.funct3;
    sb.dm_wd     = head_entry.data;
    sb.ld_stall  = drain && sb.ld_valid;
  end

  assign sb.st_ready = !full;
  assign sb.empty    = empty;

endmodule

// File: tb/tb_store_buffer.sv
// Store buffer bench: directed scenarios plus random traffic against a queue/memory model.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned AW       = SB_ADDR_W;
  localparam int unsigned DW       = SB_DATA_W;
  localparam int unsigned MemWords = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mem_clear = 1'b1;
  always #5 clk = ~clk;

  store_buffer_if #(.DM_ADDRESS(AW), .DATA_W(DW)) sb_if ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .sb (sb_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return {old[31:8], nw[7:0]};
      2'b01:   return {old[31:16], nw[15:0]};
      default: return nw;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3);
    case (f3)
      F3_B:    return {{24{w[7]}}, w[7:0]};
      F3_H:    return {{16{w[15]}}, w[15:0]};
      F3_BU:   return {24'h0, w[7:0]};
      F3_HU:   return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Datamemory stand-in driven purely by the DUT's port signals.
  logic [DW-1:0] dmem [MemWords];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < MemWords; i++) dmem[i] <= '0;
    end else if (sb_if.dm_write) begin
      dmem[sb_if.dm_addr] <= merge(dmem[sb_if.dm_addr], sb_if.dm_wd, sb_if.dm_funct3);
    end
  end

  // Reference: program-order memory image plus the queue of not-yet-written stores.
  logic [DW-1:0] arch [MemWords];
  sb_entry_t     pend [$];
  logic          last_stall;
  logic [31:0]   last_rd;

  task automatic step(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                      input logic [2:0] sf, input logic lv, input logic [AW-1:0] la,
                      input logic [2:0] lf);
    logic full, hit, grant, drain;
    sb_entry_t hd;
    @(negedge clk);
    sb_if.st_valid  = sv;
    sb_if.st_addr   = sa;
    sb_if.st_data   = sd;
    sb_if.st_funct3 = sf;
    sb_if.ld_valid  = lv;
    sb_if.ld_addr   = la;
    sb_if.ld_funct3 = lf;
    #2;
    full = (pend.size() == DEPTH);
    hit  = 1'b0;
    foreach (pend[i]) if (pend[i].addr == la) hit = 1'b1;
    hit   = hit && lv;
    grant = lv && !hit && !full;
    drain = !grant && (pend.size() != 0);
    check_eq("st_ready", sb_if.st_ready, !full);
    check_eq("empty", sb_if.empty, pend.size() == 0);
    check_eq("ld_stall", sb_if.ld_stall, lv && !grant);
    check_eq("dm_read", sb_if.dm_read, grant);
    check_eq("dm_write", sb_if.dm_write, drain);
    if (grant) begin
      last_rd = load_ext(dmem[sb_if.dm_addr], sb_if.dm_funct3);
      check_eq("ld_addr", sb_if.dm_addr, la);
      check_eq("ld_funct3", sb_if.dm_funct3, lf);
      check_eq("ld_data", last_rd, load_ext(arch[la], lf));
    end
    if (drain) begin
      hd = pend[0];
      check_eq("drain_addr", sb_if.dm_addr, hd.addr);
      check_eq("drain_wd", sb_if.dm_wd, hd.data);
      check_eq("drain_funct3", sb_if.dm_funct3, hd.funct3);
    end
    last_stall = lv && !grant;
    @(posedge clk);
    if (drain) void'(pend.pop_front());
    if (sv && !full) begin
      pend.push_back('{addr: sa, data: sd, funct3: sf});
      arch[sa] = merge(arch[sa], sd, sf);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, F3_W, 1'b0, '0, F3_W);
  endtask

  // Bounded: a load that never gets the port shows up as a wrong stall count.
  task automatic load_until_grant(input logic [AW-1:0] la, input logic [2:0] lf,
                                  input int exp_stalls, input string tag);
    int n = 0;
    do begin
      step(1'b0, '0, '0, F3_W, 1'b1, la, lf);
      if (last_stall) n++;
    end while (last_stall && n < 10);
    check_eq(tag, n, exp_stalls);
  endtask

  initial begin
    logic          sv, lv;
    logic [AW-1:0] sa, la;
    logic [DW-1:0] sd;
    logic [2:0]    sf, lf;
    logic [2:0]    st_f3 [3];
    logic [2:0]    ld_f3 [5];
    st_f3 = '{F3_B, F3_H, F3_W};
    ld_f3 = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
    last_stall = 1'b0;
    last_rd    = '0;
    for (int i = 0; i < MemWords; i++) arch[i] = '0;
    sb_if.st_valid  = 1'b0;
    sb_if.st_addr   = '0;
    sb_if.st_data   = '0;
    sb_if.st_funct3 = F3_W;
    sb_if.ld_valid  = 1'b0;
    sb_if.ld_addr   = '0;
    sb_if.ld_funct3 = F3_W;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_clear = 1'b0;
    check_eq("rst_st_ready", sb_if.st_ready, 1'b1);
    check_eq("rst_empty", sb_if.empty, 1'b1);
    check_eq("rst_dm_write", sb_if.dm_write, 1'b0);
    check_eq("rst_dm_read", sb_if.dm_read, 1'b0);
    check_eq("rst_ld_stall", sb_if.ld_stall, 1'b0);
    rst = 1'b1;

    // Single SW then read back.
    step(1'b1, 9'd5, 32'hDEADBEEF, F3_W, 1'b0, '0, F3_W);
    idle(2);
    load_until_grant(9'd5, F3_W, 0, "t1_stalls");
    check_eq("t1_rd", last_rd, 32'hDEADBEEF);

    // Fill with unrelated loads granted until full, then one forced drain.
    for (int i = 1; i <= 4; i++) step(1'b1, AW'(i), 32'h100 + i, F3_W, 1'b1, 9'd9, F3_W);
    load_until_grant(9'd9, F3_W, 1, "t2_stalls");
    idle(6);

    // Byte store hazard on the next load.
    step(1'b1, 9'd7, 32'h000000AB, F3_B, 1'b0, '0, F3_W);
    load_until_grant(9'd7, F3_B, 1, "t3_stalls");
    check_eq("t3_rd", last_rd, 32'hFFFFFFAB);
    idle(3);

    // Store offered while full is refused, then accepted next cycle.
    for (int i = 11; i <= 14; i++) step(1'b1, AW'(i), 32'h200 + i, F3_W, 1'b1, 9'd9, F3_W);
    step(1'b1, 9'd6, 32'h600D, F3_W, 1'b1, 9'd9, F3_W);
    step(1'b1, 9'd6, 32'h600D, F3_W, 1'b1, 9'd9, F3_W);
    check_eq("t4_pending", pend.size(), DEPTH);
    idle(6);

    // Same-address stores drain in order.
    step(1'b1, 9'd3, 32'h11, F3_W, 1'b1, 9'd9, F3_W);
    step(1'b1, 9'd3, 32'h22, F3_W, 1'b1, 9'd9, F3_W);
    load_until_grant(9'd3, F3_W, 2, "t5_stalls");
    check_eq("t5_rd", last_rd, 32'h22);
    idle(3);

    // Asynchronous reset with three entries pending.
    for (int i = 20; i <= 22; i++) step(1'b1, AW'(i), 32'h300 + i, F3_W, 1'b1, 9'd9, F3_W);
    @(negedge clk);
    sb_if.st_valid = 1'b0;
    sb_if.ld_valid = 1'b0;
    #1;
    check_eq("pre_rst_drain", sb_if.dm_write, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    check_eq("arst_empty", sb_if.empty, 1'b1);
    check_eq("arst_st_ready", sb_if.st_ready, 1'b1);
    check_eq("arst_dm_write", sb_if.dm_write, 1'b0);
    pend.delete();
    for (int i = 0; i < MemWords; i++) arch[i] = dmem[i];
    @(negedge clk);
    rst = 1'b1;
    idle(5);
    last_stall = 1'b0;

    // Random traffic; a stalled load is held and blocks the store slot.
    lf = F3_W;
    la = '0;
    for (int c = 0; c < 3000; c++) begin
      if (last_stall) begin
        sv = 1'b0;
        lv = 1'b1;
      end else begin
        sv = ($urandom_range(0, 9) < 5) && (pend.size() < DEPTH);
        lv = ($urandom_range(0, 9) < 4);
        la = AW'($urandom_range(0, 7));
        lf = ld_f3[$urandom_range(0, 4)];
      end
      sa = AW'($urandom_range(0, 7));
      sd = $urandom;
      sf = st_f3[$urandom_range(0, 2)];
      step(sv, sa, sd, sf, lv, la, lf);
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
